// File: rtl/sram_1rw_arbiter.sv
// sram_1rw_arbiter: two-requester round-robin controller for a single-port 1rw SRAM macro.
//
// The wrapper builds the tri-state bus as DATA = sram_wdata_oe ? sram_wdata : 'z
// and feeds DATA back as sram_rdata.
//
// Ports:
//   clk, reset                      clock shared with the macro; synchronous active-high reset
//   reqN_valid/ready/we/addr/wdata  command handshake per requester (N = 0, 1)
//   rsp_valid/rsp_id/rsp_rdata      read response; one-cycle pulse, no backpressure
//   sram_addr/csb/web/oeb           macro control pins; csb, web and oeb are active low
//   sram_wdata/sram_wdata_oe        write data and bus-drive enable
//   sram_rdata                      DATA bus as seen by the controller
module sram_1rw_arbiter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic                  sram_oeb,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    output logic                  sram_wdata_oe,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD1  = 2'd2,
        ST_RD2  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  pend_id_q, pend_id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic                  oeb_q, oeb_d;
    logic                  oe_q, oe_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  window;
    logic                  gnt0;
    logic                  gnt1;

    // Grant, next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        pend_id_d    = pend_id_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_rdata_d  = rsp_rdata_q;
        gnt0         = 1'b0;
        gnt1         = 1'b0;

        // RD1 must hold the address for the second read edge, so no grant there
        window = (state_q != ST_RD1) && !reset;

        // On a tie the requester that was not granted last wins
        if (window) begin
            if (req0_valid && (!req1_valid || last_grant_q)) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end

        if (gnt0 || gnt1) begin
            last_grant_d = gnt1;
            pend_id_d    = gnt1;
            addr_d       = gnt1 ? req1_addr  : req0_addr;
            wdata_d      = gnt1 ? req1_wdata : req0_wdata;
            state_d      = (gnt1 ? req1_we : req0_we) ? ST_WR : ST_RD1;
        end else if (state_q == ST_RD1) begin
            state_d = ST_RD2;
        end else begin
            state_d = ST_IDLE;
        end

        // Bus data settled during RD2; capture it on the edge leaving RD2
        if (state_q == ST_RD2) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = pend_id_q;
            rsp_rdata_d = sram_rdata;
        end

        // Pins are registered from the next state so they line up with it
        csb_d = (state_d == ST_IDLE);
        web_d = (state_d != ST_WR);
        oeb_d = !((state_d == ST_RD1) || (state_d == ST_RD2));
        oe_d  = (state_d == ST_WR);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            pend_id_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            csb_q        <= 1'b1;
            web_q        <= 1'b1;
            oeb_q        <= 1'b1;
            oe_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pend_id_q    <= pend_id_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            csb_q        <= csb_d;
            web_q        <= web_d;
            oeb_q        <= oeb_d;
            oe_q         <= oe_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign req0_ready    = gnt0;
    assign req1_ready    = gnt1;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign sram_addr     = addr_q;
    assign sram_csb      = csb_q;
    assign sram_web      = web_q;
    assign sram_oeb      = oeb_q;
    assign sram_wdata    = wdata_q;
    assign sram_wdata_oe = oe_q;

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// tb_sram_1rw_arbiter: directed bench for sram_1rw_arbiter with a behavioural 1rw macro model.
module tb_sram_1rw_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req0_ready, req0_we = 1'b0;
    logic [9:0]  req0_addr = '0;
    logic [63:0] req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_ready, req1_we = 1'b0;
    logic [9:0]  req1_addr = '0;
    logic [63:0] req1_wdata = '0;
    logic        rsp_valid, rsp_id;
    logic [63:0] rsp_rdata;
    logic [9:0]  sram_addr;
    logic        sram_csb, sram_web, sram_oeb, sram_wdata_oe;
    logic [63:0] sram_wdata, sram_rdata;

    int checks = 0;
    int errors = 0;

    // Macro model: writes the bus at the edge, read data appears 3 units after the edge
    logic [63:0] mem [0:1023];
    logic [63:0] rd_bus = '0;
    logic [9:0]  rd_a;
    assign sram_rdata = sram_wdata_oe ? sram_wdata : rd_bus;

    always @(posedge clk) begin
        if (!sram_csb && !sram_web) mem[sram_addr] <= sram_rdata;
    end

    always @(posedge clk) begin
        if (!sram_csb && sram_web && !sram_oeb) begin
            rd_a = sram_addr;
            #3;
            rd_bus = mem[rd_a];
        end
    end

    always #5 clk = ~clk;

    sram_1rw_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(10)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .sram_addr(sram_addr), .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
        .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe), .sram_rdata(sram_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; req0_we = 1'b1; req1_we = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b exp 00", {req0_ready, req1_ready}); end
        step();
        checks++; if ({sram_csb, sram_web, sram_oeb, sram_wdata_oe} !== 4'b1110) begin errors++; $display("FAIL reset_pins: got %b exp 1110", {sram_csb, sram_web, sram_oeb, sram_wdata_oe}); end
        checks++; if ({rsp_valid, rsp_id} !== 2'b00) begin errors++; $display("FAIL reset_rsp: got %b exp 00", {rsp_valid, rsp_id}); end
        checks++; if (rsp_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", rsp_rdata); end
        checks++; if (sram_addr !== 10'h0 || sram_wdata !== 64'h0) begin errors++; $display("FAIL reset_addr_wdata: got %h/%h exp 0/0", sram_addr, sram_wdata); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready_held: got %b exp 00", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        do_reset();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 10'h3FF; req0_wdata = 64'hDEADBEEF_CAFEF00D;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL wr_first_ready: got %b exp 10", {req0_ready, req1_ready}); end
        step();
        checks++; if ({sram_csb, sram_web, sram_oeb, sram_wdata_oe} !== 4'b0011) begin errors++; $display("FAIL wr_pins: got %b exp 0011", {sram_csb, sram_web, sram_oeb, sram_wdata_oe}); end
        checks++; if (sram_addr !== 10'h3FF || sram_wdata !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL wr_addr_data: got %h/%h exp 3ff/deadbeefcafef00d", sram_addr, sram_wdata); end
        req0_we = 1'b0;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rd_ready_in_wr: got %b exp 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        checks++; if ({sram_csb, sram_web, sram_oeb, sram_wdata_oe} !== 4'b0100) begin errors++; $display("FAIL rd1_pins: got %b exp 0100", {sram_csb, sram_web, sram_oeb, sram_wdata_oe}); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_lat1: got %b exp 0", rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_lat2: got %b exp 0", rsp_valid); end
        step();
        checks++; if ({rsp_valid, rsp_id} !== 2'b10) begin errors++; $display("FAIL rd_rsp: got %b exp 10", {rsp_valid, rsp_id}); end
        checks++; if (rsp_rdata !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL rd_data: got %h exp deadbeefcafef00d", rsp_rdata); end
        step();
        checks++; if ({rsp_valid, sram_csb} !== 2'b01) begin errors++; $display("FAIL rd_pulse_end: got %b exp 01", {rsp_valid, sram_csb}); end
    endtask

    task automatic test_rr_writes();
        logic exp;
        do_reset();
        req0_we = 1'b1; req0_addr = 10'h010; req0_wdata = 64'h0000_0000_0000_0A0A;
        req1_we = 1'b1; req1_addr = 10'h020; req1_wdata = 64'h0000_0000_0000_0B0B;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp = 1'(i % 2);
            checks++; if ({req0_ready, req1_ready} !== {!exp, exp}) begin errors++; $display("FAIL rr_grant%0d: got %b exp %b", i, {req0_ready, req1_ready}, {!exp, exp}); end
            step();
            checks++; if (sram_addr !== (exp ? 10'h020 : 10'h010) || sram_web !== 1'b0) begin errors++; $display("FAIL rr_write%0d: got addr %h web %b", i, sram_addr, sram_web); end
            #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        checks++; if (mem[10'h010] !== 64'h0A0A || mem[10'h020] !== 64'h0B0B) begin errors++; $display("FAIL rr_mem: got %h/%h exp a0a/b0b", mem[10'h010], mem[10'h020]); end
    endtask

    task automatic test_dual_reads();
        do_reset();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 10'h005; req0_wdata = 64'h5555_0000_5555_0005;
        #1; step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 10'h006; req1_wdata = 64'h6666_0000_6666_0006;
        #1; step();
        req0_valid = 1'b1; req0_we = 1'b0;
        req1_valid = 1'b1; req1_we = 1'b0;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL dual_first: got %b exp 10", {req0_ready, req1_ready}); end
        step();
        req0_valid = 1'b0;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL dual_rd1_ready: got %b exp 00", {req0_ready, req1_ready}); end
        step();
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL dual_rd2_ready: got %b exp 1", req1_ready); end
        step();
        req1_valid = 1'b0;
        checks++; if ({rsp_valid, rsp_id} !== 2'b10 || rsp_rdata !== 64'h5555_0000_5555_0005) begin errors++; $display("FAIL dual_rsp0: got %b %h", {rsp_valid, rsp_id}, rsp_rdata); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL dual_gap: got %b exp 0", rsp_valid); end
        step();
        checks++; if ({rsp_valid, rsp_id} !== 2'b11 || rsp_rdata !== 64'h6666_0000_6666_0006) begin errors++; $display("FAIL dual_rsp1: got %b %h", {rsp_valid, rsp_id}, rsp_rdata); end
    endtask

    task automatic test_raw();
        do_reset();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 10'h00A; req0_wdata = 64'hFFFF;
        #1; step();
        checks++; if (sram_wdata_oe && !sram_oeb) begin errors++; $display("FAIL raw_contention0: oe %b oeb %b", sram_wdata_oe, sram_oeb); end
        req0_wdata = 64'h1;
        #1; step();
        checks++; if (sram_wdata_oe && !sram_oeb) begin errors++; $display("FAIL raw_contention1: oe %b oeb %b", sram_wdata_oe, sram_oeb); end
        req0_we = 1'b0;
        #1; step();
        req0_valid = 1'b0;
        checks++; if (sram_wdata_oe && !sram_oeb) begin errors++; $display("FAIL raw_contention2: oe %b oeb %b", sram_wdata_oe, sram_oeb); end
        step();
        checks++; if (sram_wdata_oe && !sram_oeb) begin errors++; $display("FAIL raw_contention3: oe %b oeb %b", sram_wdata_oe, sram_oeb); end
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h1) begin errors++; $display("FAIL raw_data: got %b %h exp 1 1", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_reset_rd1();
        do_reset();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'h100;
        #1; step();
        checks++; if (sram_oeb !== 1'b0) begin errors++; $display("FAIL rst_rd1_entry: got oeb %b exp 0", sram_oeb); end
        reset = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 10'h011; req0_wdata = 64'h11;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 10'h022; req1_wdata = 64'h22;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL rst_rd1_ready: got %b exp 00", {req0_ready, req1_ready}); end
        step();
        checks++; if ({rsp_valid, sram_csb, sram_web, sram_oeb, sram_wdata_oe} !== 5'b01110 || sram_addr !== 10'h0) begin errors++; $display("FAIL rst_rd1_state: got %b addr %h", {rsp_valid, sram_csb, sram_web, sram_oeb, sram_wdata_oe}, sram_addr); end
        reset = 1'b0;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rst_rd1_tie: got %b exp 10", {req0_ready, req1_ready}); end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rd1_norsp0: got %b exp 0", rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rd1_norsp1: got %b exp 0", rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_rr_writes();
        test_dual_reads();
        test_raw();
        test_reset_rd1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
